// File: rtl/game_pkg.sv
// Shared game-level types: screen encoding and finish-screen timing default.
package game_pkg;

  typedef enum logic [1:0] {
    SCR_START  = 2'b00,
    SCR_PLAY   = 2'b01,
    SCR_FINISH = 2'b10
  } screen_t;

  // Frames the finish screen stays up before a start press is honoured
  localparam int unsigned MIN_FINISH_FRAMES_DFLT = 180;

  // Counter width able to hold 0..max inclusive, never narrower than 1 bit
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants and the registered VGA stream payload.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;
  localparam int unsigned CNT_W      = 11;
  localparam int unsigned RGB_W      = 12;

  // One pixel-clock slice of the VGA stream
  typedef struct packed {
    logic [CNT_W-1:0] vcount;
    logic [CNT_W-1:0] hcount;
    logic             vsync;
    logic             hsync;
    logic             vblnk;
    logic             hblnk;
    logic [RGB_W-1:0] rgb;
  } vga_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing + pixel bundle; 'out' drives the stream, 'in' consumes it.
interface vga_if;
  import vga_pkg::*;

  logic [CNT_W-1:0] vcount;
  logic [CNT_W-1:0] hcount;
  logic             vsync;
  logic             hsync;
  logic             vblnk;
  logic             hblnk;
  logic [RGB_W-1:0] rgb;

  modport out (
    output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

  modport in (
    input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

  modport master (
    output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

  modport slave (
    input vcount, hcount, vsync, hsync, vblnk, hblnk, rgb
  );

endinterface

// File: rtl/screen_ctrl_btn_edge.sv
// Button synchronizer and rising-edge pulse generator.
// The pulse only arms after a valid "released" sample has passed through the
// synchronizer, so a button held through reset never fires on reset release.
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] vld_q,   vld_d;
  logic       armed_q, armed_d;
  logic       pulse_q, pulse_d;

  // Next-state: shift the synchronizer, track pipeline validity, detect 0->1
  always_comb begin
    sync1_d = btn_i;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    armed_d = vld_q[1] & ~sync2_q;
    pulse_d = armed_q & sync2_q;
  end

  // Registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld_q   <= 2'b00;
      armed_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      vld_q   <= vld_d;
      armed_q <= armed_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/screen_ctrl.sv
// Game-screen sequencer: START -> PLAY -> FINISH -> START, switching only on
// the rising edge of vblnk, and muxing the matching renderer onto vga_out.
module screen_ctrl
  import game_pkg::*, vga_pkg::*;
#(
  parameter int unsigned MIN_FINISH_FRAMES = MIN_FINISH_FRAMES_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_btn,
  input  logic             game_over,
  input  logic [RGB_W-1:0] rgb_start,
  input  logic [RGB_W-1:0] rgb_game,
  input  logic [RGB_W-1:0] rgb_finish,
  vga_if.in                vga_in,
  vga_if.out               vga_out,
  output logic [1:0]       screen,
  output logic             game_rst,
  output logic             game_en
);

  localparam int unsigned      FIN_W   = cnt_width(MIN_FINISH_FRAMES);
  localparam logic [FIN_W-1:0] FIN_MAX = FIN_W'(MIN_FINISH_FRAMES);

  localparam logic [1:0] ST_START  = 2'(SCR_START);
  localparam logic [1:0] ST_PLAY   = 2'(SCR_PLAY);
  localparam logic [1:0] ST_FINISH = 2'(SCR_FINISH);

  logic [1:0]       state_q,     state_d;
  logic             start_req_q, start_req_d;
  logic             over_req_q,  over_req_d;
  logic [FIN_W-1:0] fin_cnt_q,   fin_cnt_d;
  logic             vblnk_q;
  logic             game_rst_q,  game_rst_d;
  logic             game_en_q,   game_en_d;
  vga_t             vga_q,       vga_d;

  logic start_evt_c;
  logic frame_tick_c;
  logic unused_rgb_c;

  // Renderer timing comes in with its own rgb field, which is not used here
  assign unused_rgb_c = ^vga_in.rgb;

  // Start button: synchronize and turn presses into one-cycle events
  btn_edge u_btn_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_i   (start_btn),
    .pulse_o (start_evt_c)
  );

  // Frame boundary marks the first cycle of vertical blanking
  assign frame_tick_c = vga_in.vblnk & ~vblnk_q;

  // FSM next-state, sticky request flags and finish-frame counter
  always_comb begin
    state_d     = state_q;
    start_req_d = start_req_q;
    over_req_d  = over_req_q;
    fin_cnt_d   = fin_cnt_q;

    case (state_q)
      ST_START: begin
        if (start_evt_c) begin
          start_req_d = 1'b1;
        end
        if (frame_tick_c && start_req_q) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        // start presses are dropped here; only game_over matters
        if (game_over) begin
          over_req_d = 1'b1;
        end
        if (frame_tick_c && over_req_q) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        if (start_evt_c && (fin_cnt_q == FIN_MAX)) begin
          start_req_d = 1'b1;
        end
        if (frame_tick_c) begin
          if (start_req_q) begin
            state_d = ST_START;
          end else if (fin_cnt_q != FIN_MAX) begin
            fin_cnt_d = fin_cnt_q + FIN_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_START;
      end
    endcase

    // Any screen change starts the new screen with no pending requests
    if (state_d != state_q) begin
      start_req_d = 1'b0;
      over_req_d  = 1'b0;
    end

    if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
      fin_cnt_d = '0;
    end
  end

  // Gameplay controls follow the next state so they line up with screen
  always_comb begin
    game_rst_d = (state_q == ST_START) && (state_d == ST_PLAY);
    game_en_d  = (state_d == ST_PLAY);
  end

  // Output stream: timing passes through, rgb picked by the current screen
  always_comb begin
    vga_d        = '0;
    vga_d.vcount = vga_in.vcount;
    vga_d.hcount = vga_in.hcount;
    vga_d.vsync  = vga_in.vsync;
    vga_d.hsync  = vga_in.hsync;
    vga_d.vblnk  = vga_in.vblnk;
    vga_d.hblnk  = vga_in.hblnk;
    if (!(vga_in.vblnk || vga_in.hblnk)) begin
      case (state_q)
        ST_START:  vga_d.rgb = rgb_start;
        ST_PLAY:   vga_d.rgb = rgb_game;
        ST_FINISH: vga_d.rgb = rgb_finish;
        default:   vga_d.rgb = '0;
      endcase
    end
  end

  // All state and outputs registered with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_START;
      start_req_q <= 1'b0;
      over_req_q  <= 1'b0;
      fin_cnt_q   <= '0;
      vblnk_q     <= 1'b0;
      game_rst_q  <= 1'b0;
      game_en_q   <= 1'b0;
      vga_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_req_q <= start_req_d;
      over_req_q  <= over_req_d;
      fin_cnt_q   <= fin_cnt_d;
      vblnk_q     <= vga_in.vblnk;
      game_rst_q  <= game_rst_d;
      game_en_q   <= game_en_d;
      vga_q       <= vga_d;
    end
  end

  assign screen   = state_q;
  assign game_rst = game_rst_q;
  assign game_en  = game_en_q;

  assign vga_out.vcount = vga_q.vcount;
  assign vga_out.hcount = vga_q.hcount;
  assign vga_out.vsync  = vga_q.vsync;
  assign vga_out.hsync  = vga_q.hsync;
  assign vga_out.vblnk  = vga_q.vblnk;
  assign vga_out.hblnk  = vga_q.hblnk;
  assign vga_out.rgb    = vga_q.rgb;

endmodule
